// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    // Loader phases: accept program bytes, hold the core in reset, then serve fetches.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Drop one byte into the big-endian slot selected by idx (0 = bits [31:24]).
    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0] w,
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] b
    );
        logic [WORD_W-1:0] r;
        r = w;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream load port plus the core's word-fetch port.
//
// Handshake: a byte moves on a rising clock edge where s_valid and s_ready are
// both high. s_ready never depends on s_valid. The source must hold s_data and
// s_last stable while s_valid is high and the byte has not yet been taken.
// s_last is only meaningful together with s_valid.
interface imem_loader_if #(
    parameter int ADDR_SIZE = 8
) ();
    import imem_loader_pkg::*;

    logic                 s_valid;
    logic                 s_ready;
    logic [BYTE_W-1:0]    s_data;
    logic                 s_last;
    logic [ADDR_SIZE-1:0] raddr;
    logic [WORD_W-1:0]    rdata;

    // Master drives the stream and the fetch address (testbench / core side).
    modport master (
        output s_valid, s_data, s_last, raddr,
        input  s_ready, rdata
    );

    // Slave is the loader itself.
    modport slave (
        input  s_valid, s_data, s_last, raddr,
        output s_ready, rdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words. Low bytes of a short final word
// read as zero because the shift register is cleared after every word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,      // synchronous, active-low
    input  logic              clear,      // synchronous flush of any partial word
    input  logic              in_accept,  // a byte transfers on this edge
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              word_done,  // this edge completes a word
    output logic [WORD_W-1:0] word,       // completed word, valid with word_done
    output logic [IDX_W-1:0]  byte_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;

    // Merge the incoming byte and decide whether the word closes on this edge.
    always_comb begin
        word       = place_byte(shift_q, byte_idx_q, in_data);
        word_done  = in_accept && ((byte_idx_q == LAST_IDX) || in_last);
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        if (clear) begin
            shift_d    = '0;
            byte_idx_d = '0;
        end else if (in_accept) begin
            if (word_done) begin
                shift_d    = '0;
                byte_idx_d = '0;
            end else begin
                shift_d    = word;
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    // Packing state; reset discards a half-built word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign byte_idx = byte_idx_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader/responder for a single-cycle core's fetch port.
// Loads a byte stream into word storage, holds the core in reset for a short
// interval, then serves combinational fetches until a restart is requested.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset,        // synchronous, active-low
    imem_loader_if.slave       bus,
    input  logic               restart,
    output logic               core_reset,
    output logic               loaded,
    output logic [ADDR_SIZE:0] word_count,
    output logic               err_partial,
    output logic               err_overflow,
    output state_t             state_dbg,
    output logic [IDX_W-1:0]   byte_idx_dbg
);

    localparam int                 DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_PTR  = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [7:0]         HOLD_LAST = 8'(RESET_HOLD - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

    state_t             state_q, state_d;
    logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               err_partial_q, err_partial_d;
    logic               err_overflow_q, err_overflow_d;
    logic               s_ready_q, s_ready_d;
    logic               core_reset_q, core_reset_d;
    logic               loaded_q, loaded_d;

    logic [WORD_W-1:0]  mem_q [DEPTH];

    logic               accept;
    logic               run_restart;
    logic               word_done;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   byte_idx;
    logic               mem_we;

    assign accept      = bus.s_valid && s_ready_q;
    assign run_restart = (state_q == RUN) && restart;

    imem_loader_byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (run_restart),
        .in_accept (accept),
        .in_data   (bus.s_data),
        .in_last   (bus.s_last),
        .word_done (word_done),
        .word      (word),
        .byte_idx  (byte_idx)
    );

    // Next-state logic for the load/hold/run sequencer and its bookkeeping.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;
        mem_we         = 1'b0;
        case (state_q)
            LOAD: begin
                // Words past the end of storage are dropped; the pointer saturates.
                if (word_done) begin
                    if (wr_ptr_q != FULL_PTR) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        err_overflow_d = 1'b1;
                    end
                end
                if (accept && bus.s_last) begin
                    if (byte_idx != LAST_IDX) begin
                        err_partial_d = 1'b1;
                    end
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (restart) begin
                    state_d        = LOAD;
                    wr_ptr_d       = '0;
                    hold_cnt_d     = '0;
                    err_partial_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        // Outputs are registered from the next state so they change on the same edge.
        s_ready_d    = (state_d == LOAD);
        core_reset_d = (state_d != RUN);
        loaded_d     = (state_d == RUN);
    end

    // Sequencer registers, counters, sticky errors and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= LOAD;
            wr_ptr_q       <= '0;
            hold_cnt_q     <= '0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            s_ready_q      <= 1'b1;
            core_reset_q   <= 1'b1;
            loaded_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
            s_ready_q      <= s_ready_d;
            core_reset_q   <= core_reset_d;
            loaded_q       <= loaded_d;
        end
    end

    // Word storage; contents survive reset, only the fill pointer is cleared.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= word;
        end
    end

    // Zero-latency fetch; addresses not yet written read as zero.
    always_comb begin
        bus.rdata = '0;
        if ({1'b0, bus.raddr} < wr_ptr_q) begin
            bus.rdata = mem_q[bus.raddr];
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign core_reset    = core_reset_q;
    assign loaded        = loaded_q;
    assign word_count    = wr_ptr_q;
    assign err_partial   = err_partial_q;
    assign err_overflow  = err_overflow_q;
    assign state_dbg     = state_q;
    assign byte_idx_dbg  = byte_idx;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a word-queue model of the loaded program is checked
// against the DUT on every falling edge, plus directed literal checks.
module tb_imem_loader;
    import imem_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT A: 256 words ----------------
    imem_loader_if #(.ADDR_SIZE(8)) bus_a ();
    logic         restart_a = 1'b0;
    logic         core_reset_a, loaded_a, err_partial_a, err_overflow_a;
    logic [8:0]   word_count_a;
    state_t       state_a;
    logic [1:0]   byte_idx_a;

    imem_loader #(.ADDR_SIZE(8), .RESET_HOLD(4)) dut_a (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_a),
        .restart      (restart_a),
        .core_reset   (core_reset_a),
        .loaded       (loaded_a),
        .word_count   (word_count_a),
        .err_partial  (err_partial_a),
        .err_overflow (err_overflow_a),
        .state_dbg    (state_a),
        .byte_idx_dbg (byte_idx_a)
    );

    // ---------------- DUT B: 4 words, overflow case ----------------
    imem_loader_if #(.ADDR_SIZE(2)) bus_b ();
    logic         restart_b = 1'b0;
    logic         core_reset_b, loaded_b, err_partial_b, err_overflow_b;
    logic [2:0]   word_count_b;
    state_t       state_b;
    logic [1:0]   byte_idx_b;

    imem_loader #(.ADDR_SIZE(2), .RESET_HOLD(4)) dut_b (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_b),
        .restart      (restart_b),
        .core_reset   (core_reset_b),
        .loaded       (loaded_b),
        .word_count   (word_count_b),
        .err_partial  (err_partial_b),
        .err_overflow (err_overflow_b),
        .state_dbg    (state_b),
        .byte_idx_dbg (byte_idx_b)
    );

    // ---------------- fetch address muxing ----------------
    bit         sweep_en = 1'b1;
    logic [7:0] sweep_addr = 8'd0;
    logic [7:0] dir_addr_a = 8'd0;
    logic [1:0] dir_addr_b = 2'd0;
    assign bus_a.raddr = sweep_en ? sweep_addr : dir_addr_a;
    assign bus_b.raddr = dir_addr_b;

    // ---------------- scoreboard / model ----------------
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_q[$];      // words that must be in DUT A memory, in order
    logic [7:0]  cur_q[$];      // bytes of the word being assembled
    bit          model_partial = 1'b0;
    bit          model_overflow = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream semantics: bytes fill a word MSB first; a word closes at 4 bytes
    // or at last (zero-padded); words beyond 256 are dropped.
    task automatic model_accept(input logic [7:0] b, input bit last);
        logic [31:0] w;
        cur_q.push_back(b);
        if (cur_q.size() == 4 || last) begin
            w = 32'h0;
            for (int i = 0; i < cur_q.size(); i++) begin
                w[31 - 8*i -: 8] = cur_q[i];
            end
            if (exp_q.size() < 256) exp_q.push_back(w);
            else model_overflow = 1'b1;
            if (cur_q.size() < 4) model_partial = 1'b1;
            cur_q.delete();
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_q.delete();
        model_partial = 1'b0;
        model_overflow = 1'b0;
    endtask

    // Per-cycle comparison of DUT A against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            int unsigned a;
            logic [31:0] exp_rd;
            a = bus_a.raddr;
            exp_rd = (a < exp_q.size()) ? exp_q[a] : 32'h0;
            check("cmp_word_count", word_count_a, exp_q.size());
            check("cmp_err_partial", err_partial_a, model_partial);
            check("cmp_err_overflow", err_overflow_a, model_overflow);
            check("cmp_rdata", bus_a.rdata, exp_rd);
        end
        sweep_addr = (sweep_addr == 8'd15) ? 8'd0 : sweep_addr + 8'd1;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input int tgt, input logic [7:0] b, input bit last);
        logic rdy;
        if (tgt == 0) begin
            bus_a.s_valid = 1'b1; bus_a.s_data = b; bus_a.s_last = last;
            rdy = bus_a.s_ready;
        end else begin
            bus_b.s_valid = 1'b1; bus_b.s_data = b; bus_b.s_last = last;
            rdy = bus_b.s_ready;
        end
        @(posedge clock);
        if (tgt == 0 && rdy) model_accept(b, last);
        #1;
        bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        model_clear();
        #1;
        reset = 1'b1;
    endtask

    task automatic pulse_restart(input bit in_run);
        restart_a = 1'b1;
        @(posedge clock);
        if (in_run) model_clear();
        #1;
        restart_a = 1'b0;
    endtask

    task automatic wait_run(input int tgt);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clock);
            #1;
            done = (tgt == 0) ? loaded_a : loaded_b;
        end
        check("wait_run", done, 1'b1);
    endtask

    task automatic peek_a(input string name, input logic [7:0] addr, input logic [31:0] exp);
        sweep_en = 1'b0;
        dir_addr_a = addr;
        #1;
        check(name, bus_a.rdata, exp);
        sweep_en = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(0, w[31 - 8*i -: 8], last && (i == 3));
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] prog [9] = '{32'h00631826, 32'h2063000a, 32'h00421026, 32'h00210826,
                              32'h10230003, 32'h00411020, 32'h20210001, 32'h1000fffc,
                              32'h0040000d};
    logic [7:0] part [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.s_valid = 1'b0; bus_a.s_data = 8'h0; bus_a.s_last = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_data = 8'h0; bus_b.s_last = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();

        // Reset state.
        check("rst_s_ready", bus_a.s_ready, 1'b1);
        check("rst_core_reset", core_reset_a, 1'b1);
        check("rst_loaded", loaded_a, 1'b0);
        check("rst_state", state_a, LOAD);
        check("rst_word_count", word_count_a, 9'd0);
        check("rst_errors", {err_partial_a, err_overflow_a}, 2'b00);
        chk_en = 1'b1;

        // Full 9-word program, back to back.
        for (int w = 0; w < 9; w++) send_word(prog[w], w == 8, 0);
        check("prog_state_hold", state_a, HOLD);
        check("prog_ready_low", bus_a.s_ready, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            check("prog_core_reset_hold", core_reset_a, (k < 4) ? 1'b1 : 1'b0);
        end
        check("prog_loaded", loaded_a, 1'b1);
        check("prog_word_count", word_count_a, 9'd9);
        peek_a("prog_rdata_4", 8'd4, 32'h10230003);
        peek_a("prog_rdata_9", 8'd9, 32'h00000000);
        send_byte(0, 8'h55, 1'b1);   // ignored in RUN
        check("run_ignores_stream", word_count_a, 9'd9);

        // Restart from RUN.
        pulse_restart(1'b1);
        check("restart_core_reset", core_reset_a, 1'b1);
        check("restart_word_count", word_count_a, 9'd0);
        check("restart_errors", {err_partial_a, err_overflow_a}, 2'b00);
        check("restart_ready", bus_a.s_ready, 1'b1);

        // Partial final word; a restart during HOLD must be ignored.
        for (int i = 0; i < 6; i++) send_byte(0, part[i], i == 5);
        pulse_restart(1'b0);
        wait_run(0);
        check("part_word_count", word_count_a, 9'd2);
        check("part_err_partial", err_partial_a, 1'b1);
        peek_a("part_mem0", 8'd0, 32'hAABBCCDD);
        peek_a("part_mem1", 8'd1, 32'hEEFF0000);

        // Random idle gaps between bytes.
        pulse_restart(1'b1);
        send_word(32'h2063000a, 1'b0, 3);
        send_word(32'h00411020, 1'b1, 3);
        wait_run(0);
        check("gap_word_count", word_count_a, 9'd2);
        peek_a("gap_mem0", 8'd0, 32'h2063000a);
        peek_a("gap_mem1", 8'd1, 32'h00411020);

        // Single-word reload.
        pulse_restart(1'b1);
        send_word(32'h0000000d, 1'b1, 0);
        wait_run(0);
        peek_a("reload_mem0", 8'd0, 32'h0000000d);

        // Reset after two bytes of a word discards them.
        pulse_restart(1'b1);
        send_byte(0, 8'h99, 1'b0);
        send_byte(0, 8'h88, 1'b0);
        do_reset();
        check("mid_rst_byte_idx", byte_idx_a, 2'd0);
        check("mid_rst_state", state_a, LOAD);
        check("mid_rst_word_count", word_count_a, 9'd0);
        send_word(32'h11223344, 1'b1, 0);
        wait_run(0);
        check("mid_rst_count_after", word_count_a, 9'd1);
        peek_a("mid_rst_mem0", 8'd0, 32'h11223344);

        // Overflow on the 4-word instance: 20 bytes, 5th word dropped.
        for (int i = 0; i < 20; i++) begin
            check("ovf_ready", bus_b.s_ready, 1'b1);
            send_byte(1, 8'(i + 1), i == 19);
        end
        check("ovf_state_hold", state_b, HOLD);
        check("ovf_word_count", word_count_b, 3'd4);
        check("ovf_err_overflow", err_overflow_b, 1'b1);
        check("ovf_err_partial", err_partial_b, 1'b0);
        dir_addr_b = 2'd0;
        #1;
        check("ovf_mem0", bus_b.rdata, 32'h01020304);
        dir_addr_b = 2'd3;
        #1;
        check("ovf_mem3", bus_b.rdata, 32'h0d0e0f10);
        wait_run(1);

        chk_en = 1'b0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
